// File: rtl/addr_decode_dtack.sv
// CPU address decoder with a programmable region table and wait-state DTACK generation.
// Define ADDR_DECODE_BERR_EN to enable Berr_L on unmapped accesses and external-ack timeout.
module addr_decode_dtack #(
  parameter int ADDR_W         = 32,
  parameter int NUM_REGIONS    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   Clk,
  input  logic                   Reset_L,
  input  logic [ADDR_W-1:0]      Address,
  input  logic                   AS_L,
  input  logic                   ExtDtack_L,
  input  logic                   CfgWrite_H,
  input  logic [2:0]             CfgIndex,
  input  logic [ADDR_W-1:0]      CfgBase,
  input  logic [ADDR_W-1:0]      CfgMask,
  input  logic [3:0]             CfgWaits,
  input  logic                   CfgEnable,
  output logic [NUM_REGIONS-1:0] Select_H,
  output logic                   Dtack_L,
  output logic                   Berr_L
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_EXT  = 3'd2,
    S_ACK  = 3'd3,
    S_BERR = 3'd4
  } state_t;

  function automatic logic [ADDR_W-1:0] rst_base(input int idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'h0000_0000;
      1:       v = 32'h0800_0000;
      2:       v = 32'h0040_0000;
      3:       v = 32'hF000_0000;
      default: v = 32'h0000_0000;
    endcase
    return ADDR_W'(v);
  endfunction

  function automatic logic [ADDR_W-1:0] rst_mask(input int idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'hFFFF_8000;
      1:       v = 32'hFFFC_0000;
      2:       v = 32'hFFFF_0000;
      3:       v = 32'hFC00_0000;
      default: v = 32'h0000_0000;
    endcase
    return ADDR_W'(v);
  endfunction

  function automatic logic [3:0] rst_waits(input int idx);
    logic [3:0] v;
    case (idx)
      2:       v = 4'd1;
      3:       v = 4'd2;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d;
  logic                   dtack_l_q, dtack_l_d;
  logic                   armed_q, armed_d;
`ifdef ADDR_DECODE_BERR_EN
  logic                   berr_l_q, berr_l_d;
`endif

  logic [ADDR_W-1:0]      base_q  [NUM_REGIONS];
  logic [ADDR_W-1:0]      base_d  [NUM_REGIONS];
  logic [ADDR_W-1:0]      mask_q  [NUM_REGIONS];
  logic [ADDR_W-1:0]      mask_d  [NUM_REGIONS];
  logic [3:0]             waits_q [NUM_REGIONS];
  logic [3:0]             waits_d [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_q, en_d;

  logic                   hit_s;
  logic [NUM_REGIONS-1:0] hit_sel_s;
  logic [3:0]             hit_waits_s;

  // Window compare; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_s       = 1'b0;
    hit_sel_s   = '0;
    hit_waits_s = 4'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (en_q[i] && ((Address & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
        hit_s        = 1'b1;
        hit_sel_s    = '0;
        hit_sel_s[i] = 1'b1;
        hit_waits_s  = waits_q[i];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Table write port; indices beyond NUM_REGIONS never match and are dropped.
  always_comb begin
    base_d  = base_q;
    mask_d  = mask_q;
    waits_d = waits_q;
    en_d    = en_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (CfgWrite_H && (int'(CfgIndex) == i)) begin
        base_d[i]  = CfgBase;
        mask_d[i]  = CfgMask;
        waits_d[i] = CfgWaits;
        en_d[i]    = CfgEnable;
      end else begin
        en_d[i] = en_q[i];
      end
    end
  end

  // Bus-cycle FSM next state; a cycle only starts once AS_L has been seen high since the last one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    dtack_l_d = 1'b1;
    armed_d   = armed_q;
`ifdef ADDR_DECODE_BERR_EN
    berr_l_d  = 1'b1;
`endif
    if (AS_L) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        cnt_d = '0;
        if (!AS_L && armed_q) begin
          armed_d = 1'b0;
          sel_d   = hit_sel_s;
          if (!hit_s) begin
`ifdef ADDR_DECODE_BERR_EN
            state_d = S_BERR;
`else
            state_d = S_ACK;
`endif
          end else if (hit_waits_s == 4'd0) begin
            state_d = S_ACK;
          end else if (hit_waits_s == 4'hF) begin
            state_d = S_EXT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(hit_waits_s);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EXT: begin
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (!ExtDtack_L) begin
          state_d = S_ACK;
          cnt_d   = '0;
`ifdef ADDR_DECODE_BERR_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_BERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          cnt_d = cnt_q;
        end
`endif
      end
      S_ACK: begin
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end else begin
          dtack_l_d = 1'b0;
        end
      end
      S_BERR: begin
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end else begin
`ifdef ADDR_DECODE_BERR_EN
          berr_l_d = 1'b0;
`else
          state_d = S_IDLE;
          sel_d   = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // All state, including the region table, with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      dtack_l_q <= 1'b1;
      armed_q   <= 1'b0;
`ifdef ADDR_DECODE_BERR_EN
      berr_l_q  <= 1'b1;
`endif
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= rst_base(i);
        mask_q[i]  <= rst_mask(i);
        waits_q[i] <= rst_waits(i);
        en_q[i]    <= (i < 4);
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      dtack_l_q <= dtack_l_d;
      armed_q   <= armed_d;
`ifdef ADDR_DECODE_BERR_EN
      berr_l_q  <= berr_l_d;
`endif
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= base_d[i];
        mask_q[i]  <= mask_d[i];
        waits_q[i] <= waits_d[i];
        en_q[i]    <= en_d[i];
      end
    end
  end

  assign Select_H = sel_q;
  assign Dtack_L  = dtack_l_q;
`ifdef ADDR_DECODE_BERR_EN
  assign Berr_L   = berr_l_q;
`else
  assign Berr_L   = 1'b1;
`endif

endmodule

// File: tb/tb_addr_decode_dtack.sv
// Directed self-checking bench for addr_decode_dtack (default 4 regions, 64-cycle timeout).
module tb_addr_decode_dtack;

  logic        Clk = 1'b0;
  logic        Reset_L;
  logic [31:0] Address;
  logic        AS_L;
  logic        ExtDtack_L;
  logic        CfgWrite_H;
  logic [2:0]  CfgIndex;
  logic [31:0] CfgBase;
  logic [31:0] CfgMask;
  logic [3:0]  CfgWaits;
  logic        CfgEnable;
  logic [3:0]  Select_H;
  logic        Dtack_L;
  logic        Berr_L;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] t_addr [4] = '{32'h0000_1000, 32'h0800_0010, 32'h0040_0010, 32'hF012_3456};
  logic [3:0]  t_sel  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int          t_lat  [4] = '{1, 1, 2, 3};

  addr_decode_dtack #(.ADDR_W(32), .NUM_REGIONS(4), .TIMEOUT_CYCLES(64)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .AS_L(AS_L), .ExtDtack_L(ExtDtack_L),
    .CfgWrite_H(CfgWrite_H), .CfgIndex(CfgIndex), .CfgBase(CfgBase), .CfgMask(CfgMask),
    .CfgWaits(CfgWaits), .CfgEnable(CfgEnable), .Select_H(Select_H), .Dtack_L(Dtack_L),
    .Berr_L(Berr_L)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] base, input logic [31:0] mask,
                           input logic [3:0] waits, input logic en);
    CfgIndex = idx; CfgBase = base; CfgMask = mask; CfgWaits = waits; CfgEnable = en;
    CfgWrite_H = 1'b1;
    tick();
    CfgWrite_H = 1'b0;
  endtask

  // Leaves the bench just after E0 of a new cycle.
  task automatic start(input logic [31:0] addr);
    AS_L = 1'b1;
    tick();
    tick();
    Address = addr;
    AS_L = 1'b0;
    tick();
  endtask

  task automatic release_and_check(input string name);
    AS_L = 1'b1;
    tick();
    n_checks++;
    if (Select_H !== 4'b0000 || Dtack_L !== 1'b1 || Berr_L !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_clear: got sel=%b dtack=%b berr=%b want sel=0000 dtack=1 berr=1", name, Select_H, Dtack_L, Berr_L);
    end
  endtask

  task automatic test_reset();
    Reset_L = 1'b0; AS_L = 1'b1; ExtDtack_L = 1'b1; CfgWrite_H = 1'b0; Address = 32'h0;
    CfgIndex = 3'd0; CfgBase = 32'h0; CfgMask = 32'h0; CfgWaits = 4'd0; CfgEnable = 1'b0;
    tick();
    tick();
    n_checks++;
    if (Select_H !== 4'b0000) begin n_fails++; $display("FAIL reset_sel: got %b want 0000", Select_H); end
    n_checks++;
    if (Dtack_L !== 1'b1) begin n_fails++; $display("FAIL reset_dtack: got %b want 1", Dtack_L); end
    n_checks++;
    if (Berr_L !== 1'b1) begin n_fails++; $display("FAIL reset_berr: got %b want 1", Berr_L); end
    Reset_L = 1'b1;
    tick();
  endtask

  task automatic test_wait_states();
    for (int r = 0; r < 4; r++) begin
      start(t_addr[r]);
      n_checks++;
      if (Select_H !== t_sel[r] || Dtack_L !== 1'b1) begin
        n_fails++;
        $display("FAIL ws%0d_e0: got sel=%b dtack=%b want sel=%b dtack=1", r, Select_H, Dtack_L, t_sel[r]);
      end
      for (int k = 1; k <= 5; k++) begin
        logic exp_dtack;
        tick();
        exp_dtack = (k >= t_lat[r]) ? 1'b0 : 1'b1;
        n_checks++;
        if (Dtack_L !== exp_dtack || Select_H !== t_sel[r] || Berr_L !== 1'b1) begin
          n_fails++;
          $display("FAIL ws%0d_e0+%0d: got dtack=%b sel=%b berr=%b want dtack=%b sel=%b berr=1",
                   r, k, Dtack_L, Select_H, Berr_L, exp_dtack, t_sel[r]);
        end
      end
      release_and_check("ws");
    end
  endtask

  task automatic test_unmapped();
    // index 5 is beyond the table and must not create a window at 0x2xxxxxxx
    cfg_write(3'd5, 32'h2000_0000, 32'hF000_0000, 4'd0, 1'b1);
    start(32'h2000_0000);
    n_checks++;
    if (Select_H !== 4'b0000) begin n_fails++; $display("FAIL unmapped_sel: got %b want 0000", Select_H); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
`ifdef ADDR_DECODE_BERR_EN
      if (Berr_L !== 1'b0 || Dtack_L !== 1'b1) begin
        n_fails++; $display("FAIL unmapped_e0+%0d: got berr=%b dtack=%b want berr=0 dtack=1", k, Berr_L, Dtack_L);
      end
`else
      if (Dtack_L !== 1'b0 || Berr_L !== 1'b1) begin
        n_fails++; $display("FAIL unmapped_e0+%0d: got dtack=%b berr=%b want dtack=0 berr=1", k, Dtack_L, Berr_L);
      end
`endif
    end
    release_and_check("unmapped");
  endtask

  task automatic test_overlap_enable();
    cfg_write(3'd2, 32'h0000_0000, 32'hFFFF_0000, 4'd1, 1'b1);
    start(32'h0000_1000);
    n_checks++;
    if (Select_H !== 4'b0001) begin n_fails++; $display("FAIL overlap_sel: got %b want 0001", Select_H); end
    tick();
    n_checks++;
    if (Dtack_L !== 1'b0) begin n_fails++; $display("FAIL overlap_dtack: got %b want 0", Dtack_L); end
    release_and_check("overlap");
    cfg_write(3'd0, 32'h0000_0000, 32'hFFFF_8000, 4'd0, 1'b0);
    start(32'h0000_1000);
    n_checks++;
    if (Select_H !== 4'b0100) begin n_fails++; $display("FAIL disabled_sel: got %b want 0100", Select_H); end
    tick();
    n_checks++;
    if (Dtack_L !== 1'b1) begin n_fails++; $display("FAIL disabled_e0+1: got %b want 1", Dtack_L); end
    tick();
    n_checks++;
    if (Dtack_L !== 1'b0) begin n_fails++; $display("FAIL disabled_e0+2: got %b want 0", Dtack_L); end
    release_and_check("disabled");
    cfg_write(3'd0, 32'h0000_0000, 32'hFFFF_8000, 4'd0, 1'b1);
    cfg_write(3'd2, 32'h0040_0000, 32'hFFFF_0000, 4'd1, 1'b1);
  endtask

  task automatic test_ext_ack();
    cfg_write(3'd1, 32'h0800_0000, 32'hFFFC_0000, 4'hF, 1'b1);
    start(32'h0800_0010);
    n_checks++;
    if (Select_H !== 4'b0010) begin n_fails++; $display("FAIL ext_sel: got %b want 0010", Select_H); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (Dtack_L !== 1'b1 || Berr_L !== 1'b1) begin
        n_fails++; $display("FAIL ext_e0+%0d: got dtack=%b berr=%b want 1 1", k, Dtack_L, Berr_L);
      end
    end
    ExtDtack_L = 1'b0;
    tick();
    n_checks++;
    if (Dtack_L !== 1'b1) begin n_fails++; $display("FAIL ext_e0+5: got %b want 1", Dtack_L); end
    ExtDtack_L = 1'b1;
    tick();
    n_checks++;
    if (Dtack_L !== 1'b0) begin n_fails++; $display("FAIL ext_e0+6: got %b want 0", Dtack_L); end
    tick();
    n_checks++;
    if (Dtack_L !== 1'b0 || Select_H !== 4'b0010) begin
      n_fails++; $display("FAIL ext_hold: got dtack=%b sel=%b want 0 0010", Dtack_L, Select_H);
    end
    release_and_check("ext");
  endtask

  task automatic test_timeout();
    start(32'h0800_0010);
    for (int k = 1; k <= 63; k++) begin
      tick();
      n_checks++;
      if (Dtack_L !== 1'b1 || Berr_L !== 1'b1) begin
        n_fails++; $display("FAIL timeout_e0+%0d: got dtack=%b berr=%b want 1 1", k, Dtack_L, Berr_L);
      end
    end
    tick();
    tick();
    n_checks++;
`ifdef ADDR_DECODE_BERR_EN
    if (Berr_L !== 1'b0 || Dtack_L !== 1'b1) begin
      n_fails++; $display("FAIL timeout_berr: got berr=%b dtack=%b want 0 1", Berr_L, Dtack_L);
    end
`else
    for (int k = 0; k < 10; k++) tick();
    if (Dtack_L !== 1'b1 || Berr_L !== 1'b1) begin
      n_fails++; $display("FAIL timeout_noack: got dtack=%b berr=%b want 1 1", Dtack_L, Berr_L);
    end
`endif
    release_and_check("timeout");
    cfg_write(3'd1, 32'h0800_0000, 32'hFFFC_0000, 4'd0, 1'b1);
  endtask

  task automatic test_abort();
    start(32'hF000_0000);
    tick();
    AS_L = 1'b1;
    tick();
    n_checks++;
    if (Select_H !== 4'b0000 || Dtack_L !== 1'b1) begin
      n_fails++; $display("FAIL abort_clear: got sel=%b dtack=%b want 0000 1", Select_H, Dtack_L);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (Dtack_L !== 1'b1 || Berr_L !== 1'b1) begin
        n_fails++; $display("FAIL abort_noack%0d: got dtack=%b berr=%b want 1 1", k, Dtack_L, Berr_L);
      end
    end
  endtask

  task automatic test_same_edge_write();
    AS_L = 1'b1;
    tick();
    tick();
    Address = 32'hF000_0000;
    AS_L = 1'b0;
    CfgIndex = 3'd3; CfgBase = 32'hF000_0000; CfgMask = 32'hFC00_0000; CfgWaits = 4'd0; CfgEnable = 1'b1;
    CfgWrite_H = 1'b1;
    tick();
    CfgWrite_H = 1'b0;
    n_checks++;
    if (Select_H !== 4'b1000) begin n_fails++; $display("FAIL sameedge_sel: got %b want 1000", Select_H); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (Dtack_L !== ((k >= 3) ? 1'b0 : 1'b1)) begin
        n_fails++; $display("FAIL sameedge_e0+%0d: got %b want %b", k, Dtack_L, (k >= 3) ? 1'b0 : 1'b1);
      end
    end
    release_and_check("sameedge");
    start(32'hF000_0000);
    tick();
    n_checks++;
    if (Dtack_L !== 1'b0) begin n_fails++; $display("FAIL newtable_e0+1: got %b want 0", Dtack_L); end
    release_and_check("newtable");
  endtask

  task automatic test_reset_mid_cycle();
    start(32'hF000_0000);
    tick();
    Reset_L = 1'b0;
    tick();
    n_checks++;
    if (Select_H !== 4'b0000 || Dtack_L !== 1'b1 || Berr_L !== 1'b1) begin
      n_fails++; $display("FAIL midreset: got sel=%b dtack=%b berr=%b want 0000 1 1", Select_H, Dtack_L, Berr_L);
    end
    Reset_L = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (Dtack_L !== 1'b1 || Select_H !== 4'b0000) begin
        n_fails++; $display("FAIL nodouble%0d: got dtack=%b sel=%b want 1 0000", k, Dtack_L, Select_H);
      end
    end
    // reset restored region3 to 2 waits
    start(32'hF000_0000);
    n_checks++;
    if (Select_H !== 4'b1000) begin n_fails++; $display("FAIL rearm_sel: got %b want 1000", Select_H); end
    tick();
    tick();
    n_checks++;
    if (Dtack_L !== 1'b1) begin n_fails++; $display("FAIL rearm_e0+2: got %b want 1", Dtack_L); end
    tick();
    n_checks++;
    if (Dtack_L !== 1'b0) begin n_fails++; $display("FAIL rearm_e0+3: got %b want 0", Dtack_L); end
    release_and_check("rearm");
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_unmapped();
    test_overlap_enable();
    test_ext_ack();
    test_timeout();
    test_abort();
    test_same_edge_write();
    test_reset_mid_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
